serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, sysclk cycles per serial bit period; legal range 8..65535.
REQ-002 SHALL have port sysclk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port serialIn  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-005 SHALL have port rx_data  output  8  head-of-FIFO byte, valid only while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts head byte when rx_valid&rx_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun  output  1  sticky; byte dropped because FIFO full.
REQ-010 SHALL have port busy  output  1  high whenever FSM not in IDLE.

Function
REQ-011 SHALL pass serialIn through a 2-flop synchronizer; all decoding uses the synchronized signal only.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, RECOVER.
REQ-013 IDLE: synchronized line sampled 0 -> START, bit timer cleared.
REQ-014 START: at CLKS_PER_BIT/2 (integer divide) cycles, sample line; 0 -> DATA with timer and bit index cleared; 1 -> IDLE (glitch rejected, no flag).
REQ-015 DATA: every CLKS_PER_BIT cycles sample one bit into shift register, LSB first; after bit index 7 -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; 1 -> push byte, -> IDLE; 0 -> frame_err pulse, byte discarded, -> RECOVER.
REQ-017 RECOVER: remain until synchronized line is 1, then -> IDLE.
REQ-018 Bit timer SHALL be 16 bits, reset to 0 at each sample point; no cumulative drift.
REQ-019 FIFO SHALL be 4 entries, first-word-fall-through, 2-bit pointers wrapping 3->0, 3-bit occupancy count.
REQ-020 Push SHALL make rx_valid high on the cycle after the stop-bit sample when FIFO was empty.
REQ-021 Pop on rx_valid&rx_ready; rx_data SHALL present the next entry the following cycle.
REQ-022 rx_ready while empty SHALL have no effect; count never underflows.
REQ-023 Push when count=4 with no simultaneous pop SHALL drop byte, leave FIFO unchanged, set overrun.
REQ-024 Simultaneous push and pop when full SHALL accept both; count stays 4; no overrun.
REQ-025 Simultaneous push and pop when empty is impossible (rx_valid=0); push proceeds normally.
REQ-026 overrun SHALL clear only on reset.

Reset
REQ-027 reset low SHALL immediately force FSM=IDLE, timer=0, bit index=0, FIFO pointers/count=0, synchronizer flops=1.
REQ-028 Reset values: rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0.
REQ-029 Reset mid-frame SHALL discard partial byte; after release, the first falling edge starts a new frame.

Configuration
REQ-030 Macro SERIAL_RX_PARITY_EN defined: frame is 8E1; PARITY state between DATA and STOP samples parity bit; even-parity mismatch SHALL pulse output parity_err (1 bit) for one cycle and discard byte, continuing to STOP for framing.
REQ-031 Macro undefined: no PARITY state, no parity_err port; frame is 8N1.

Verification (bench CLKS_PER_BIT=16)
REQ-032 Send 0x41 (8N1), rx_ready=1 -> rx_valid pulse with rx_data=0x41, frame_err=0, overrun=0.
REQ-033 Drive serialIn low for 4 cycles then high -> FSM returns IDLE, no push, busy low within 12 cycles.
REQ-034 Send 0x55 with stop bit 0 -> frame_err one-cycle pulse, FIFO empty; line held high then 0x0F sent -> rx_data=0x0F.
REQ-035 rx_ready=0, send 0x01..0x05 -> first four queued in order, 0x05 dropped, overrun=1; drain -> 0x01,0x02,0x03,0x04.
REQ-036 Assert reset during DATA bit 3 of 0xA5, release, send 0x3C -> only 0x3C received.
REQ-037 With SERIAL_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no push; with parity 1 -> rx_data=0x07.

Source files
------------

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module     : serial_rx
// Description: UART-style serial receiver. 2-flop input synchronizer,
//              start/data/stop decoding FSM with a 16-bit bit timer, and a
//              4-entry first-word-fall-through FIFO with sticky overrun.
//              Define SERIAL_RX_PARITY_EN to receive 8E1 frames (adds the
//              PARITY state and the parity_err output); default is 8N1.
// Revision   : 1.0 - initial release
// ============================================================================
module serial_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       serialIn,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef SERIAL_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // Sample points: start bit checked at its middle, every later bit one
    // full period after the previous sample (timer restarts at each sample).
    localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;
`endif

    logic        sync1_q, sync2_q;
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, frame_err_d;
    logic        push_w;
`ifdef SERIAL_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    logic        parity_err_q, parity_err_d;
`endif

    logic [7:0]  mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        overrun_q;
    logic        pop_w, full_w, wr_en_w;

    // Input synchronizer; flops reset to the idle-high line level.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serialIn;
            sync2_q <= sync1_q;
        end
    end

    // FSM state, bit timer, shift register and pulse outputs.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state decode; push_w is asserted on the good stop-bit sample.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        frame_err_d  = 1'b0;
        push_w       = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!sync2_q) state_d = S_START;
            end
            S_START: begin
                if (timer_q == c_HALF_LAST) begin
                    timer_d = '0;
                    if (!sync2_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (timer_q == c_BIT_LAST) begin
                    timer_d   = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
                if (timer_q == c_BIT_LAST) begin
                    timer_d = '0;
                    state_d = S_STOP;
                    // Even parity: data ones plus parity bit must be even.
                    if ((^shift_q) != sync2_q) begin
                        par_bad_d    = 1'b1;
                        parity_err_d = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (timer_q == c_BIT_LAST) begin
                    timer_d = '0;
                    if (sync2_q) begin
`ifdef SERIAL_RX_PARITY_EN
                        push_w = !par_bad_q;
`else
                        push_w = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                timer_d = '0;
                if (sync2_q) state_d = S_IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign pop_w   = rx_valid & rx_ready;
    assign full_w  = (count_q == 3'd4);
    assign wr_en_w = push_w & (!full_w | pop_w);

    // FIFO storage, pointers, occupancy and sticky overrun flag.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en_w) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_w) rd_ptr_q <= rd_ptr_q + 2'd1;
            if (wr_en_w && !pop_w)      count_q <= count_q + 3'd1;
            else if (!wr_en_w && pop_w) count_q <= count_q - 3'd1;
            if (push_w && full_w && !pop_w) overrun_q <= 1'b1;
        end
    end

    assign rx_valid  = (count_q != 3'd0);
    assign rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module     : tb_serial_rx
// Description: Self-checking bench for serial_rx (CLKS_PER_BIT=16). Directed
//              frames plus random frames compared to an expected-byte queue.
//              Honours SERIAL_RX_PARITY_EN for 8E1 framing.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         fe_cnt   = 0;
    bit         fe_long  = 1'b0;
    bit         fe_prev  = 1'b0;
    int         pe_cnt   = 0;

    serial_rx #(.CLKS_PER_BIT(C)) dut (
        .sysclk    (clk),
        .reset     (rst_n),
        .serialIn  (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Collect accepted bytes and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (frame_err && fe_prev) fe_long = 1'b1;
        fe_prev = frame_err;
`ifdef SERIAL_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_period(input logic v);
        serial_in = v;
        repeat (C) @(negedge clk);
    endtask

    // One full frame; par_bit only used when parity framing is enabled.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef SERIAL_RX_PARITY_EN
        bit_period(par_bit);
`endif
        bit_period(stop_bit);
        serial_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n_before;
        logic [7:0] b;
        bit good;
        int exp_fe;

        serial_in = 1'b1;
        rx_ready  = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_valid",  rx_valid,  1'b0);
        check("reset_rx_data",   rx_data,   8'h00);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun",   overrun,   1'b0);
        check("reset_busy",      busy,      1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic 0x41 reception.
        rx_ready = 1'b1;
        send_frame(8'h41, 1'b1, ^8'h41);
        check("basic_count", got.size(), 1);
        if (got.size() > 0) check("basic_data", got[0], 8'h41);
        check("basic_frame_err", fe_cnt, 0);
        check("basic_overrun", overrun, 1'b0);

        // Short glitch is rejected.
        n_before = got.size();
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("glitch_busy_low", busy, 1'b0);
        repeat (C) @(negedge clk);
        check("glitch_no_push", got.size(), n_before);
        check("glitch_no_ferr", fe_cnt, 0);

        // Bad stop bit, then recovery with 0x0F.
        send_frame(8'h55, 1'b0, ^8'h55);
        repeat (C) @(negedge clk);
        check("ferr_pulse_count", fe_cnt, 1);
        check("ferr_one_cycle", fe_long, 1'b0);
        check("ferr_fifo_empty", rx_valid, 1'b0);
        check("ferr_no_push", got.size(), n_before);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        check("recover_count", got.size(), n_before + 1);
        if (got.size() > n_before) check("recover_data", got[n_before], 8'h0F);

        // Overflow: five frames into a four-entry FIFO with no consumer.
        rx_ready = 1'b0;
        got.delete();
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, ^b);
        end
        check("ovr_flag", overrun, 1'b1);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_head", rx_data, 8'h01);
        rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("ovr_drain_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("ovr_drain_data", got[i], 32'(i + 1));
        check("ovr_empty_after", rx_valid, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Reset during data bit 3 of 0xA5, then 0x3C.
        got.delete();
        b = 8'hA5;
        bit_period(1'b0);
        for (int i = 0; i < 3; i++) bit_period(b[i]);
        serial_in = b[3];
        repeat (C / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        check("midrst_count", got.size(), 1);
        if (got.size() > 0) check("midrst_data", got[0], 8'h3C);

`ifdef SERIAL_RX_PARITY_EN
        // Parity: 0x07 has three ones, so the even parity bit is 1.
        got.delete();
        pe_cnt = 0;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_bad_pulse", pe_cnt, 1);
        check("par_bad_no_push", got.size(), 0);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_good_count", got.size(), 1);
        if (got.size() > 0) check("par_good_data", got[0], 8'h07);
        check("par_good_no_pulse", pe_cnt, 1);
`endif

        // Random frames against an expected-byte queue.
        got.delete();
        exp_q.delete();
        fe_cnt = 0;
        exp_fe = 0;
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good, ^b);
            if (good) exp_q.push_back(b);
            else exp_fe++;
            repeat ($urandom_range(2, 20)) @(negedge clk);
        end
        check("rand_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check("rand_data", got[i], exp_q[i]);
        check("rand_frame_errs", fe_cnt, exp_fe);
        check("rand_fifo_empty", rx_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
